mix_forward_param: RTL

MIX_FORWARD_PARAM -- requirements
Module: mix_forward_param

---
 rtl/mix_forward_param_if.sv | 37 +++
 rtl/mix_forward_param.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/mix_forward_param_if.sv
// Beat, control and result bundle for mix_forward_param.
// The master drives stimulus and beats; the slave (the datapath) drives status and results.
interface mix_forward_param_if #(
  parameter int unsigned DATA_N    = 6,
  parameter int unsigned IN_CHUNKS = 4,
  parameter int unsigned HID_DIM   = 24,
  parameter int unsigned N_LEN     = 16,
  parameter int unsigned N_LEN_W   = 16
);
  localparam int unsigned HW = (HID_DIM > 1) ? $clog2(HID_DIM) : 1;
  localparam int unsigned CW = (IN_CHUNKS > 1) ? $clog2(IN_CHUNKS) : 1;

  logic                        start;
  logic                        abort;
  logic                        relu_en;
  logic                        sat_en;
  logic                        in_valid;
  logic                        in_ready;
  logic [DATA_N*N_LEN-1:0]     d;
  logic [DATA_N*N_LEN_W-1:0]   rdata_w;
  logic [N_LEN_W-1:0]          rdata_b;
  logic [HW-1:0]               idx_h;
  logic [CW-1:0]               idx_c;
  logic                        busy;
  logic                        valid;
  logic [HID_DIM*N_LEN-1:0]    q;

  modport master (
    output start, abort, relu_en, sat_en, in_valid, d, rdata_w, rdata_b,
    input  in_ready, idx_h, idx_c, busy, valid, q
  );

  modport slave (
    input  start, abort, relu_en, sat_en, in_valid, d, rdata_w, rdata_b,
    output in_ready, idx_h, idx_c, busy, valid, q
  );
endinterface

// File: rtl/mix_forward_param.sv
// Fixed-point fully-connected layer: streams DATA_N-lane beats, accumulates IN_CHUNKS beats
// per neuron through a 3-stage pipeline, and writes HID_DIM post-processed neuron outputs.
module mix_forward_param #(
  parameter int unsigned DATA_N    = 6,
  parameter int unsigned IN_CHUNKS = 4,
  parameter int unsigned HID_DIM   = 24,
  parameter int unsigned N_LEN     = 16,
  parameter int unsigned N_LEN_W   = 16,
  parameter int unsigned F_LEN     = 8
) (
  input logic              clk,
  input logic              rst_n,
  mix_forward_param_if.slave bus
);
  localparam int unsigned ACC_LEN = N_LEN + $clog2(DATA_N * IN_CHUNKS) + 2;
  localparam int unsigned HW      = (HID_DIM > 1) ? $clog2(HID_DIM) : 1;
  localparam int unsigned CW      = (IN_CHUNKS > 1) ? $clog2(IN_CHUNKS) : 1;
  localparam int unsigned MW      = F_LEN + N_LEN;
  localparam logic [HW-1:0] HLast = HW'(HID_DIM - 1);
  localparam logic [CW-1:0] CLast = CW'(IN_CHUNKS - 1);
  localparam logic signed [ACC_LEN-1:0] SatMax = {{(ACC_LEN-N_LEN+1){1'b0}}, {(N_LEN-1){1'b1}}};
  localparam logic signed [ACC_LEN-1:0] SatMin = {{(ACC_LEN-N_LEN+1){1'b1}}, {(N_LEN-1){1'b0}}};

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StRun   = 2'd1;
  localparam logic [1:0] StDrain = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  logic [1:0]                      state_q;
  logic [HW-1:0]                   idx_h_q;
  logic [CW-1:0]                   idx_c_q;
  logic                            relu_q, sat_q, valid_q;
  logic [HID_DIM-1:0][N_LEN-1:0]   q_q;
  logic signed [ACC_LEN-1:0]       acc_q;

  logic [DATA_N-1:0][N_LEN-1:0]    s1_lane_q;
  logic                            s1_vld_q, s1_last_c_q;
  logic [HW-1:0]                   s1_h_q;
  logic [N_LEN_W-1:0]              s1_bias_q;

  logic signed [ACC_LEN-1:0]       s2_sum_q;
  logic                            s2_vld_q, s2_last_c_q;
  logic [HW-1:0]                   s2_h_q;
  logic [N_LEN_W-1:0]              s2_bias_q;

  logic [DATA_N-1:0][N_LEN-1:0]    lane_d;
  logic signed [ACC_LEN-1:0]       sum_d, bias_ext, r, r_relu;
  logic [N_LEN-1:0]                res;
  logic                            accept;

  assign accept = bus.in_valid && (state_q == StRun);

  // Product only needs MW bits: everything above the kept window is discarded anyway.
  for (genvar k = 0; k < DATA_N; k++) begin : g_lane
    logic signed [MW-1:0] a, b, p;
    assign a = {{(MW-N_LEN){bus.d[k*N_LEN+N_LEN-1]}}, bus.d[k*N_LEN +: N_LEN]};
    assign b = {{(MW-N_LEN_W){bus.rdata_w[k*N_LEN_W+N_LEN_W-1]}}, bus.rdata_w[k*N_LEN_W +: N_LEN_W]};
    assign p = a * b;
    assign lane_d[k] = N_LEN'(p >> F_LEN);
  end

  always_comb begin
    sum_d = '0;
    for (int k = 0; k < DATA_N; k++) begin
      sum_d = sum_d + {{(ACC_LEN-N_LEN){s1_lane_q[k][N_LEN-1]}}, s1_lane_q[k]};
    end
  end

  always_comb begin
    bias_ext = {{(ACC_LEN-N_LEN_W){s2_bias_q[N_LEN_W-1]}}, s2_bias_q};
    r        = acc_q + s2_sum_q + bias_ext;
    r_relu   = (relu_q && r[ACC_LEN-1]) ? '0 : r;
    res      = r_relu[N_LEN-1:0];
    if (sat_q) begin
      if (r_relu > SatMax)      res = SatMax[N_LEN-1:0];
      else if (r_relu < SatMin) res = SatMin[N_LEN-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      idx_h_q     <= '0;
      idx_c_q     <= '0;
      relu_q      <= 1'b0;
      sat_q       <= 1'b0;
      valid_q     <= 1'b0;
      q_q         <= '0;
      acc_q       <= '0;
      s1_lane_q   <= '0;
      s1_vld_q    <= 1'b0;
      s1_last_c_q <= 1'b0;
      s1_h_q      <= '0;
      s1_bias_q   <= '0;
      s2_sum_q    <= '0;
      s2_vld_q    <= 1'b0;
      s2_last_c_q <= 1'b0;
      s2_h_q      <= '0;
      s2_bias_q   <= '0;
    end else if (bus.abort) begin
      // Flushing the valid bits is what drops in-flight q writes.
      state_q  <= StIdle;
      idx_h_q  <= '0;
      idx_c_q  <= '0;
      valid_q  <= 1'b0;
      acc_q    <= '0;
      s1_vld_q <= 1'b0;
      s2_vld_q <= 1'b0;
    end else begin
      s1_vld_q <= accept;
      if (accept) begin
        s1_lane_q   <= lane_d;
        s1_last_c_q <= (idx_c_q == CLast);
        s1_h_q      <= idx_h_q;
        s1_bias_q   <= bus.rdata_b;
      end

      s2_vld_q    <= s1_vld_q;
      s2_sum_q    <= sum_d;
      s2_last_c_q <= s1_last_c_q;
      s2_h_q      <= s1_h_q;
      s2_bias_q   <= s1_bias_q;

      if (s2_vld_q) begin
        if (s2_last_c_q) begin
          q_q[s2_h_q] <= res;
          acc_q       <= '0;
        end else begin
          acc_q <= acc_q + s2_sum_q;
        end
      end

      unique case (state_q)
        StIdle, StDone: begin
          if (bus.start) begin
            state_q <= StRun;
            idx_h_q <= '0;
            idx_c_q <= '0;
            valid_q <= 1'b0;
            relu_q  <= bus.relu_en;
            sat_q   <= bus.sat_en;
          end
        end
        StRun: begin
          if (accept) begin
            if (idx_c_q == CLast) begin
              idx_c_q <= '0;
              if (idx_h_q == HLast) state_q <= StDrain;
              else                  idx_h_q <= idx_h_q + 1'b1;
            end else begin
              idx_c_q <= idx_c_q + 1'b1;
            end
          end
        end
        StDrain: begin
          if (s2_vld_q && s2_last_c_q && (s2_h_q == HLast)) begin
            state_q <= StDone;
            valid_q <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.in_ready = (state_q == StRun);
  assign bus.busy     = (state_q == StRun) || (state_q == StDrain);
  assign bus.valid    = valid_q;
  assign bus.idx_h    = idx_h_q;
  assign bus.idx_c    = idx_c_q;
  assign bus.q        = q_q;
endmodule
